pixel_accum_s2: RTL and testbench

- Downstream neighbour of the stage-2 read controller.
- Captures the 192-sample tile (3 channels × 8 rows × 8 cols) streamed out of the BRAM read port.
- Sums the three channel samples of each pixel into a 64-entry buffer, then streams the 64 sums out with a valid/ready handshake.
- Returns data_done to the controller so it can release WAIT and start the next tile.

---
 rtl/pixel_accum_s2.sv | 149 ++++++++++++++
 tb/tb_pixel_accum_s2.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_accum_s2.sv
// rtl/pixel_accum_s2.sv - per-pixel channel summing buffer with valid/ready output stream
module pixel_accum_s2 #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int N_PIX  = 64,
    parameter int N_CHA  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_a,
    input  logic [2:0]        row_addr,
    input  logic [2:0]        col_addr,
    input  logic [2:0]        cha_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_rdy,
    output logic [DATA_W+1:0] out_data,
    output logic [5:0]        out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              data_done,
    output logic              busy,
    output logic              err
);

    localparam int         SUM_W    = DATA_W + 2;
    localparam logic [7:0] TILE_CNT = 8'(N_PIX * N_CHA);
    localparam logic [5:0] LAST_IDX = 6'(N_PIX - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        STREAM  = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RD_LAT-1:0] vsr_q, vsr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [5:0]        idx_q, idx_d;
    logic              err_q, err_d;

    logic [SUM_W-1:0]  sum_q [N_PIX];

    logic              sample_v;
    logic              collect_v;
    logic              wr_en;
    logic [5:0]        wr_idx;
    logic [SUM_W-1:0]  wr_data;

    assign sample_v  = vsr_q[RD_LAT-1];
    assign collect_v = sample_v && (state_q == COLLECT);

    // Read-modify-write of the pixel sum; channel 0 overwrites so no clear pass is needed
    always_comb begin
        wr_idx  = {row_addr, col_addr};
        wr_en   = collect_v && (cha_addr < 3'd3);
        wr_data = '0;
        if (cha_addr == 3'd0) begin
            wr_data = {2'b00, data_in};
        end else begin
            wr_data = sum_q[wr_idx] + SUM_W'(data_in);
        end
    end

    // Sum buffer storage; contents after reset are irrelevant since channel 0 rewrites them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            sum_q[wr_idx] <= wr_data;
        end
    end

    // Next-state logic: read-valid pipeline, sample count, stream index and sticky error
    always_comb begin
        state_d = state_q;
        vsr_d   = vsr_q << 1;
        vsr_d[0] = enable_a;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (sample_v) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cha_addr >= 3'd3) begin
                        err_d = 1'b1;
                    end
                end
                // Only leave once every issued read has landed in the buffer
                if (data_rdy && (vsr_q == '0)) begin
                    state_d = STREAM;
                    if (cnt_q != TILE_CNT) begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                if (!data_rdy) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            vsr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsr_q   <= vsr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state; out_data follows the held index so it is stable under stall
    always_comb begin
        out_valid = (state_q == STREAM);
        data_done = (state_q == DONE);
        busy      = (state_q != COLLECT);
        out_index = idx_q;
        err       = err_q;
        out_data  = '0;
        if (state_q == STREAM) begin
            out_data = sum_q[idx_q];
        end
    end

endmodule

// File: tb/tb_pixel_accum_s2.sv
// tb/tb_pixel_accum_s2.sv - directed self-checking bench for pixel_accum_s2
module tb_pixel_accum_s2;

    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_a;
    logic [2:0] row_addr;
    logic [2:0] col_addr;
    logic [2:0] cha_addr;
    logic [7:0] data_in;
    logic       data_rdy;
    logic [9:0] out_data;
    logic [5:0] out_index;
    logic       out_valid;
    logic       out_ready;
    logic       data_done;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    int exp_sum [64];

    always #5 clk = ~clk;

    pixel_accum_s2 #(
        .DATA_W(8),
        .RD_LAT(RD_LAT),
        .N_PIX(64),
        .N_CHA(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable_a  (enable_a),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .cha_addr  (cha_addr),
        .data_in   (data_in),
        .data_rdy  (data_rdy),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_done (data_done),
        .busy      (busy),
        .err       (err)
    );

    // Controller + BRAM stand-in: sample s is pixel s%64 of channel s/64, landing RD_LAT cycles after its strobe
    task automatic feed(input int n, input int sat, input bit rdy_early);
        for (int i = 0; i < n + RD_LAT; i++) begin
            @(posedge clk);
            #1;
            enable_a = (i < n);
            if (rdy_early && i == n - 1) data_rdy = 1'b1;
            if (i >= RD_LAT) begin
                int s;
                s = i - RD_LAT;
                cha_addr = 3'(s / 64);
                {row_addr, col_addr} = 6'(s % 64);
                data_in = sat ? 8'hFF : 8'((s / 64) * 10 + ((s % 64) & 7));
            end else begin
                cha_addr = 3'd0;
                row_addr = 3'd0;
                col_addr = 3'd0;
                data_in  = 8'd0;
            end
            @(negedge clk);
            if (rdy_early && i == n + RD_LAT - 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_hold: busy=%0b required 0 while last sample lands", busy);
                end
            end
        end
        @(posedge clk);
        #1;
        enable_a = 1'b0;
        data_in  = 8'd0;
        data_rdy = 1'b1;
    endtask

    // Consume the stream, checking order, values and hold-under-stall; full runs also check DONE handshake
    task automatic run_stream(input bit bp, input int stop_at);
        int beats;
        bit prev_stall;
        logic [5:0] prev_idx;
        logic [9:0] prev_data;
        logic [9:0] e;
        beats = 0;
        prev_stall = 1'b0;
        prev_idx = '0;
        prev_data = '0;
        for (int c = 0; c < 600 && beats < stop_at; c++) begin
            @(posedge clk);
            #1;
            out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== prev_idx || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b idx=%0d data=%0d required 1 idx=%0d data=%0d",
                             out_valid, out_index, out_data, prev_idx, prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                e = 10'(exp_sum[beats]);
                checks++;
                if (out_index !== 6'(beats) || out_data !== e) begin
                    errors++;
                    $display("FAIL beat: idx=%0d data=%0d required idx=%0d data=%0d",
                             out_index, out_data, beats, e);
                end
                beats++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_idx = out_index;
            prev_data = out_data;
        end
        checks++;
        if (beats != stop_at) begin
            errors++;
            $display("FAIL stream_beats: got %0d beats required %0d", beats, stop_at);
        end
        if (stop_at == 64) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            data_rdy = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || data_done !== 1'b1) begin
                errors++;
                $display("FAIL done_rise: valid=%0b done=%0b required 0 1", out_valid, data_done);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (data_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_exit: done=%0b busy=%0b required 0 0", data_done, busy);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) exp_sum[i] = 30 + 3 * (i & 7);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || data_done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
            out_index !== 6'd0 || out_data !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b done=%0b busy=%0b err=%0b idx=%0d data=%0d required all 0",
                     out_valid, data_done, busy, err, out_index, out_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_err(input logic want, input string name);
        checks++;
        if (err !== want) begin
            errors++;
            $display("FAIL %s: err=%0b required %0b", name, err, want);
        end
    endtask

    task automatic test_full_tile();
        fill_ramp();
        feed(192, 0, 1'b0);
        run_stream(1'b0, 64);
        check_err(1'b0, "full_tile_err");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 64; i++) exp_sum[i] = 765;
        feed(192, 1, 1'b0);
        run_stream(1'b0, 64);
    endtask

    task automatic test_backpressure();
        fill_ramp();
        feed(192, 0, 1'b0);
        run_stream(1'b1, 64);
    endtask

    task automatic test_drain();
        fill_ramp();
        feed(192, 0, 1'b1);
        run_stream(1'b0, 64);
        checks++;
        if (exp_sum[63] != 51) begin
            errors++;
            $display("FAIL drain_pix63_model: model=%0d required 51", exp_sum[63]);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 64; i++) exp_sum[i] = 765;
        feed(192, 1, 1'b0);
        run_stream(1'b0, 20);
        @(posedge clk);
        #1;
        reset = 1'b1;
        data_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || data_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b done=%0b busy=%0b required 0 0 0", out_valid, data_done, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        fill_ramp();
        feed(192, 0, 1'b0);
        run_stream(1'b0, 64);
        check_err(1'b0, "after_reset_err");
    endtask

    task automatic test_short_tile();
        for (int i = 0; i < 64; i++) exp_sum[i] = (i < 36) ? 10 + 2 * (i & 7) : (i & 7);
        feed(100, 0, 1'b0);
        run_stream(1'b0, 64);
        check_err(1'b1, "short_tile_err");
    endtask

    initial begin
        reset = 1'b1;
        enable_a = 1'b0;
        row_addr = '0;
        col_addr = '0;
        cha_addr = '0;
        data_in = '0;
        data_rdy = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_tile();
        test_saturate();
        test_backpressure();
        test_drain();
        test_mid_reset();
        test_short_tile();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
